// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller with edge-latched pending bits and claim/complete.
// Define INT_CTRL_SYNC_EN to pass irq through 2-flop synchronizers before edge detection.
module int_ctrl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic [31:0]        data_in,
    input  logic               mem_rd,
    input  logic               mem_wr,
    output logic [31:0]        data_out,
    output logic               oe_data,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               hwint
);
    logic [NUM_IRQ-1:0] pending, enable, in_service, irq_q, irq_s;
    logic [NUM_IRQ-1:0] rise, elig, claim_oh, cmp_oh, w1c, clm;
    logic [31:0]        claim_val;
    logic [1:0]         off, warm;
    logic               sel, rd, wr, unused_bits;

`ifdef INT_CTRL_SYNC_EN
    localparam logic [1:0] WARM = 2'd3;
    logic [NUM_IRQ-1:0] sync1, sync2;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    localparam logic [1:0] WARM = 2'd1;
    assign irq_s = irq;
`endif

    assign sel         = addr[31:2] == BASE_ADDR[31:2];
    assign off         = addr[1:0];
    assign rd          = mem_rd && sel;
    assign wr          = mem_wr && sel;
    assign elig        = pending & enable;
    assign unused_bits = ^data_in;
    // Edges are ignored until irq_q has been reloaded from the (synchronized) line after reset
    assign rise = (warm == WARM) ? irq_s & ~irq_q : '0;
    assign w1c  = (wr && off == 2'd0) ? data_in[NUM_IRQ-1:0] : '0;
    assign clm  = (rd && off == 2'd2) ? claim_oh : '0;

    always_comb begin
        claim_oh  = '0;
        claim_val = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
                claim_val   = 32'(i + 1);
            end
        end
        for (int i = 0; i < NUM_IRQ; i++)
            cmp_oh[i] = wr && off == 2'd3 && data_in[4:0] == 5'(i + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            enable     <= '0;
            in_service <= '0;
            irq_q      <= '0;
            warm       <= '0;
        end else begin
            irq_q      <= irq_s;
            warm       <= (warm == WARM) ? warm : warm + 2'd1;
            pending    <= (pending & ~w1c & ~clm) | rise;
            in_service <= (in_service | clm) & ~cmp_oh;
            if (wr && off == 2'd1)
                enable <= data_in[NUM_IRQ-1:0];
        end
    end

    assign oe_data  = rd;
    assign data_out = !rd ? '0 :
                      off == 2'd0 ? 32'(pending) :
                      off == 2'd1 ? 32'(enable) :
                      off == 2'd2 ? claim_val : '0;
    assign hwint    = |elig && in_service == '0;
endmodule
